hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 3, meaning the number of tracked stages after decode (legal 2..6); stage 0 is execute and stage DEPTH-1 is writeback.
REQ-002 SHALL define local SELW = $clog2(DEPTH+1) as the forwarding-select width.
REQ-003 SHALL have port clk, input, 1 bit: main clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port inst_i, input, 32 bits: instruction in decode.
REQ-006 SHALL have port inst_valid_i, input, 1 bit: inst_i is meaningful.
REQ-007 SHALL have port mem_ready_i, input, 1 bit: memory stage (stage 1) can complete this cycle.
REQ-008 SHALL have port branch_taken_i, input, 1 bit: the stage-0 branch or jump resolves as taken.
REQ-009 SHALL have port stall_o, output, 1 bit: upstream holds PC and inst_i.
REQ-010 SHALL have port flush_o, output, 1 bit: the decode instruction is squashed.
REQ-011 SHALL have port fwd_a_sel_o, output, SELW bits: rs1 source; 0 = register file, k = stage k-1.
REQ-012 SHALL have port fwd_b_sel_o, output, SELW bits: rs2 source, same encoding as fwd_a_sel_o.
REQ-013 SHALL have port stage_valid_o, output, DEPTH bits: per-stage valid flags.
REQ-014 SHALL have port wb_en_o, output, 1 bit: register write this cycle.
REQ-015 SHALL have port wb_rd_o, output, 5 bits: writeback destination register.
REQ-016 SHALL have port retired_o, output, 32 bits: count of retired instructions.

Function
REQ-017 SHALL hold per stage a 32-bit instruction register and a valid bit; all outputs are combinational from these registers and the inputs, except retired_o, which is registered.
REQ-018 SHALL treat an instruction as a writer when its opcode is none of branch (1100011), store (0100011) or 0000000, and rd (bits 11:7) != 0.
REQ-019 SHALL treat rs1 as used for all opcodes except LUI, AUIPC and JAL; rs2 SHALL be used only for reg-reg, store and branch opcodes.
REQ-020 SHALL assert freeze when mem_ready_i=0 and stage 1 is valid; during freeze, stall_o=1, no stage register changes, and flush_o=0.
REQ-021 SHALL assert flush when not freezing, stage 0 is valid, its opcode is branch, JAL or JALR, and branch_taken_i=1; flush_o=1 for that cycle and stage 0 loads a bubble (valid=0) instead of inst_i.
REQ-022 SHALL assert load-use when not freezing and not flushing, stage 0 is a valid load writer, and inst_valid_i=1 with a used rs1 or rs2 equal to the stage-0 rd; stall_o=1 and stage 0 loads a bubble.
REQ-023 SHALL apply the priority freeze > flush > load-use; flush SHALL NOT assert stall_o.
REQ-024 SHALL advance otherwise: stage k+1 <= stage k for k=0..DEPTH-2, and stage 0 <= inst_i with valid = inst_valid_i.
REQ-025 SHALL also advance stages 1..DEPTH-1 during flush and load-use; only stage 0 receives the bubble.
REQ-026 SHALL set fwd_a_sel_o to k+1 for the smallest k where stage k is a valid writer with rd == inst_i[19:15] and rs1 is used, else 0; a load in stage 0 SHALL NOT be selected.
REQ-027 SHALL set fwd_b_sel_o by the same rule using inst_i[24:20] and rs2 usage.
REQ-028 SHALL drive fwd_a_sel_o and fwd_b_sel_o to 0 when inst_valid_i=0.
REQ-029 SHALL set wb_en_o=1 iff stage DEPTH-1 is a valid writer and not freezing; wb_rd_o = stage DEPTH-1 rd whenever stage DEPTH-1 is valid, else 0.
REQ-030 SHALL increment retired_o by 1, wrapping from FFFFFFFF to 0, on each edge where stage DEPTH-1 is valid and not freezing; bubbles SHALL NOT count.

Reset
REQ-031 SHALL, on rst=1 and without waiting for clk, clear all valid bits and instruction registers, set retired_o=0, and force stall_o, flush_o, fwd_*_sel_o, wb_en_o and wb_rd_o to 0.
REQ-032 SHALL discard in-flight stages when reset asserts mid-operation; the first instruction captured after rst deasserts SHALL retire DEPTH edges later.

Verification
REQ-033 SHALL cover forwarding: DEPTH=3, addi x5 then add x6,x5,x5 back-to-back -> fwd_a_sel_o=fwd_b_sel_o=1, no stall.
REQ-034 SHALL cover load-use: lw x7 then add x8,x7,x1 -> stall_o=1 for exactly one cycle, then fwd_a_sel_o=2.
REQ-035 SHALL cover taken branch: beq in stage 0 with branch_taken_i=1 -> flush_o=1 one cycle, stage_valid_o[0]=0 next cycle, and retired_o excludes the squashed instruction.
REQ-036 SHALL cover memory wait: mem_ready_i=0 for 3 cycles with stage 1 valid -> stall_o=1 and stage_valid_o unchanged for 3 cycles, wb_en_o=0, and a coincident branch_taken_i ignored.
REQ-037 SHALL cover x0 and no-forward cases: addi x0 then add x1,x0,x0 -> fwd sels 0; a store followed by a reader of its rs2 -> fwd sels 0.
REQ-038 SHALL cover async reset: rst pulsed between clk edges with 3 valid stages -> stage_valid_o=0 and retired_o=0 immediately; also DEPTH=5 with 10 instructions retires retired_o=10.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: in-order pipeline hazard unit. Tracks DEPTH stages after decode
// (stage 0 = execute, stage DEPTH-1 = writeback), resolves memory-wait freezes,
// taken-branch flushes and load-use stalls, and picks forwarding sources for
// the instruction sitting in decode.
//
// Handshake: there is no valid/ready pair on this block. inst_valid_i qualifies
// inst_i; when stall_o=1 upstream must present the same inst_i again next cycle,
// and when flush_o=1 the decode instruction is dropped (stage 0 takes a bubble).
module hazard_ctrl #(
  parameter  int DEPTH = 3,
  localparam int SELW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic             inst_valid_i,
  input  logic             mem_ready_i,
  input  logic             branch_taken_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic [SELW-1:0]  fwd_a_sel_o,
  output logic [SELW-1:0]  fwd_b_sel_o,
  output logic [DEPTH-1:0] stage_valid_o,
  output logic             wb_en_o,
  output logic [4:0]       wb_rd_o,
  output logic [31:0]      retired_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // An instruction writes the register file unless it is a branch, a store or
  // an all-zero opcode, and only when its destination is not x0.
  function automatic logic f_writer(input logic [31:0] ins);
    return (ins[6:0] != OP_BRANCH) && (ins[6:0] != OP_STORE) &&
           (ins[6:0] != 7'b0000000) && (ins[11:7] != 5'd0);
  endfunction

  function automatic logic f_uses_rs1(input logic [31:0] ins);
    return (ins[6:0] != OP_LUI) && (ins[6:0] != OP_AUIPC) && (ins[6:0] != OP_JAL);
  endfunction

  function automatic logic f_uses_rs2(input logic [31:0] ins);
    return (ins[6:0] == OP_REG) || (ins[6:0] == OP_STORE) || (ins[6:0] == OP_BRANCH);
  endfunction

  logic [31:0]      r_inst [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [31:0]      r_retired;

  logic             w_freeze;
  logic             w_flush;
  logic             w_load_use;
  logic             w_ctl0;
  logic             w_rs1_used;
  logic             w_rs2_used;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd0;
  logic [SELW-1:0]  w_fwd_a;
  logic [SELW-1:0]  w_fwd_b;
  logic             w_retire;

  // Hazard detection; priority is freeze > flush > load-use.
  always_comb begin
    w_rs1      = inst_i[19:15];
    w_rs2      = inst_i[24:20];
    w_rd0      = r_inst[0][11:7];
    w_rs1_used = inst_valid_i && f_uses_rs1(inst_i);
    w_rs2_used = inst_valid_i && f_uses_rs2(inst_i);
    w_ctl0     = (r_inst[0][6:0] == OP_BRANCH) || (r_inst[0][6:0] == OP_JAL) ||
                 (r_inst[0][6:0] == OP_JALR);
    w_freeze   = !mem_ready_i && r_valid[1];
    w_flush    = !w_freeze && r_valid[0] && w_ctl0 && branch_taken_i;
    w_load_use = !w_freeze && !w_flush && r_valid[0] &&
                 (r_inst[0][6:0] == OP_LOAD) && f_writer(r_inst[0]) &&
                 ((w_rs1_used && (w_rs1 == w_rd0)) || (w_rs2_used && (w_rs2 == w_rd0)));
    w_retire   = r_valid[DEPTH-1] && !w_freeze;
  end

  // Forwarding select: youngest matching writer wins, so scan oldest-to-youngest
  // and let later hits override. A load in stage 0 has no data yet.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_valid[k] && f_writer(r_inst[k]) &&
          ((k != 0) || (r_inst[k][6:0] != OP_LOAD))) begin
        if (w_rs1_used && (r_inst[k][11:7] == w_rs1)) w_fwd_a = SELW'(k + 1);
        if (w_rs2_used && (r_inst[k][11:7] == w_rs2)) w_fwd_b = SELW'(k + 1);
      end
    end
  end

  // Output drive; everything is held at zero while reset is asserted.
  always_comb begin
    stall_o       = !rst && (w_freeze || w_load_use);
    flush_o       = !rst && w_flush;
    fwd_a_sel_o   = rst ? '0 : w_fwd_a;
    fwd_b_sel_o   = rst ? '0 : w_fwd_b;
    stage_valid_o = r_valid;
    wb_en_o       = !rst && r_valid[DEPTH-1] && f_writer(r_inst[DEPTH-1]) && !w_freeze;
    wb_rd_o       = (!rst && r_valid[DEPTH-1]) ? r_inst[DEPTH-1][11:7] : 5'd0;
    retired_o     = r_retired;
  end

  // Stage registers: hold on freeze, otherwise shift; stage 0 takes a bubble
  // on flush or load-use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) r_inst[k] <= '0;
    end else if (!w_freeze) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_inst[k]  <= r_inst[k-1];
        r_valid[k] <= r_valid[k-1];
      end
      if (w_flush || w_load_use) begin
        r_inst[0]  <= '0;
        r_valid[0] <= 1'b0;
      end else begin
        r_inst[0]  <= inst_i;
        r_valid[0] <= inst_valid_i;
      end
    end
  end

  // Retirement counter: counts real instructions leaving writeback, wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: drives a DEPTH=3 and a DEPTH=5 hazard_ctrl with the same
// stimulus and compares both against a pipeline model built from the
// instruction-level hazard rules.
module tb_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic        mem_ready = 1'b1;
  logic        branch_taken = 1'b0;

  logic        stall3, flush3, we3;
  logic [1:0]  fa3, fb3;
  logic [2:0]  sv3;
  logic [4:0]  wr3;
  logic [31:0] ret3;

  logic        stall5, flush5, we5;
  logic [2:0]  fa5, fb5;
  logic [4:0]  sv5;
  logic [4:0]  wr5;
  logic [31:0] ret5;

  hazard_ctrl #(.DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_valid_i(inst_valid),
    .mem_ready_i(mem_ready), .branch_taken_i(branch_taken),
    .stall_o(stall3), .flush_o(flush3), .fwd_a_sel_o(fa3), .fwd_b_sel_o(fb3),
    .stage_valid_o(sv3), .wb_en_o(we3), .wb_rd_o(wr3), .retired_o(ret3)
  );

  hazard_ctrl #(.DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_valid_i(inst_valid),
    .mem_ready_i(mem_ready), .branch_taken_i(branch_taken),
    .stall_o(stall5), .flush_o(flush5), .fwd_a_sel_o(fa5), .fwd_b_sel_o(fb5),
    .stage_valid_o(sv5), .wb_en_o(we5), .wb_rd_o(wr5), .retired_o(ret5)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A pipeline is a list of (instruction, valid) slots, youngest first.
  typedef struct packed {
    logic [7:0][31:0] inst;
    logic [7:0]       valid;
    logic [31:0]      ret;
  } pipe_t;

  pipe_t m3 = '0;
  pipe_t m5 = '0;

  function automatic bit is_writer(input logic [31:0] i);
    return !(i[6:0] inside {7'b1100011, 7'b0100011, 7'b0000000}) && (i[11:7] != 0);
  endfunction
  function automatic bit reads_rs1(input logic [31:0] i);
    return !(i[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction
  function automatic bit reads_rs2(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit is_ctl(input logic [31:0] i);
    return i[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
  endfunction
  function automatic bit is_load(input logic [31:0] i);
    return i[6:0] == 7'b0000011;
  endfunction

  function automatic bit m_freeze(input pipe_t p, input bit mr);
    return !mr && p.valid[1];
  endfunction
  function automatic bit m_flush(input pipe_t p, input bit mr, input bit bt);
    return !m_freeze(p, mr) && p.valid[0] && is_ctl(p.inst[0]) && bt;
  endfunction
  function automatic bit m_lu(input pipe_t p, input logic [31:0] ins, input bit v,
                              input bit mr, input bit bt);
    logic [4:0] rd;
    rd = p.inst[0][11:7];
    if (m_freeze(p, mr) || m_flush(p, mr, bt)) return 0;
    if (!(p.valid[0] && is_load(p.inst[0]) && is_writer(p.inst[0]) && v)) return 0;
    return (reads_rs1(ins) && ins[19:15] == rd) || (reads_rs2(ins) && ins[24:20] == rd);
  endfunction

  // Source for one operand: 1 + index of the youngest completed writer of it.
  function automatic int m_fwd(input pipe_t p, input int d, input logic [31:0] ins,
                               input bit v, input bit src_b);
    logic [4:0] r;
    bit used;
    r    = src_b ? ins[24:20] : ins[19:15];
    used = src_b ? reads_rs2(ins) : reads_rs1(ins);
    if (!v || !used) return 0;
    for (int k = 0; k < d; k++)
      if (p.valid[k] && is_writer(p.inst[k]) && p.inst[k][11:7] == r &&
          !(k == 0 && is_load(p.inst[k])))
        return k + 1;
    return 0;
  endfunction

  function automatic pipe_t m_next(input pipe_t p, input int d, input logic [31:0] ins,
                                   input bit v, input bit mr, input bit bt);
    pipe_t n;
    n = p;
    if (m_freeze(p, mr)) return p;
    if (p.valid[d-1]) n.ret = p.ret + 1;
    for (int k = d - 1; k > 0; k--) begin
      n.inst[k]  = p.inst[k-1];
      n.valid[k] = p.valid[k-1];
    end
    if (m_flush(p, mr, bt) || m_lu(p, ins, v, mr, bt)) begin
      n.inst[0]  = '0;
      n.valid[0] = 1'b0;
    end else begin
      n.inst[0]  = ins;
      n.valid[0] = v;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m3 <= '0;
      m5 <= '0;
    end else begin
      m3 <= m_next(m3, 3, inst, inst_valid, mem_ready, branch_taken);
      m5 <= m_next(m5, 5, inst, inst_valid, mem_ready, branch_taken);
    end
  end

  task automatic check_dut(input string nm, input pipe_t p, input int d,
                           input logic st, input logic fl, input logic [31:0] fa,
                           input logic [31:0] fb, input logic [31:0] sv, input logic we,
                           input logic [31:0] wr, input logic [31:0] ret);
    bit fz, fls, lu;
    logic [31:0] mask;
    fz   = m_freeze(p, mem_ready);
    fls  = m_flush(p, mem_ready, branch_taken);
    lu   = m_lu(p, inst, inst_valid, mem_ready, branch_taken);
    mask = (32'd1 << d) - 32'd1;
    chk({nm, ".stall"}, 32'(st), 32'(fz || lu));
    chk({nm, ".flush"}, 32'(fl), 32'(fls));
    chk({nm, ".fwd_a"}, fa, 32'(m_fwd(p, d, inst, inst_valid, 1'b0)));
    chk({nm, ".fwd_b"}, fb, 32'(m_fwd(p, d, inst, inst_valid, 1'b1)));
    chk({nm, ".stage_valid"}, sv, 32'(p.valid) & mask);
    chk({nm, ".wb_en"}, 32'(we), 32'(p.valid[d-1] && is_writer(p.inst[d-1]) && !fz));
    chk({nm, ".wb_rd"}, wr, p.valid[d-1] ? 32'(p.inst[d-1][11:7]) : 32'd0);
    chk({nm, ".retired"}, ret, p.ret);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [31:0] ins, input bit v, input bit mr, input bit bt);
    @(negedge clk);
    inst = ins; inst_valid = v; mem_ready = mr; branch_taken = bt;
    #1;
    check_dut("d3", m3, 3, stall3, flush3, 32'(fa3), 32'(fb3), 32'(sv3), we3, 32'(wr3), ret3);
    check_dut("d5", m5, 5, stall5, flush5, 32'(fa5), 32'(fb5), 32'(sv5), we5, 32'(wr5), ret5);
  endtask

  task automatic idle();
    step(32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // Pulse reset between clock edges and confirm it acts without a clock.
  task automatic do_reset();
    @(negedge clk);
    inst = '0; inst_valid = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst.sv3", 32'(sv3), 32'd0);
    chk("rst.ret3", ret3, 32'd0);
    chk("rst.sv5", 32'(sv5), 32'd0);
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] i_add(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_lw(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] i_sw(input int rs2, input int rs1, input int imm);
    return {7'(imm >> 5), 5'(rs2), 5'(rs1), 3'b010, 5'(imm), 7'b0100011};
  endfunction
  function automatic logic [31:0] i_beq(input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b0, 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 9))
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0000011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      5: op = 7'b1101111;
      6: op = 7'b1100111;
      7: op = 7'b0110111;
      8: op = 7'b0010111;
      default: op = 7'b0000000;
    endcase
    return {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:12],
            5'($urandom_range(0, 3)), op};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset state straight after power-up.
    #1 rst = 1'b1;
    #1;
    chk("init.stall", 32'(stall3), 32'd0);
    chk("init.sv", 32'(sv3), 32'd0);
    chk("init.ret", ret3, 32'd0);
    #1 rst = 1'b0;

    // Back-to-back ALU forwarding.
    do_reset();
    step(i_addi(5, 0, 1), 1, 1, 0);
    step(i_add(6, 5, 5), 1, 1, 0);
    chk("fwd.a", 32'(fa3), 32'd1);
    chk("fwd.b", 32'(fb3), 32'd1);
    chk("fwd.stall", 32'(stall3), 32'd0);

    // Load-use: one stall, then forward from stage 1.
    do_reset();
    step(i_lw(7, 1), 1, 1, 0);
    step(i_add(8, 7, 1), 1, 1, 0);
    chk("lu.stall", 32'(stall3), 32'd1);
    step(i_add(8, 7, 1), 1, 1, 0);
    chk("lu.stall_done", 32'(stall3), 32'd0);
    chk("lu.fwd_a", 32'(fa3), 32'd2);
    chk("lu.fwd_b", 32'(fb3), 32'd0);

    // Taken branch squashes the decode instruction.
    do_reset();
    step(i_beq(1, 2), 1, 1, 0);
    step(i_addi(9, 0, 1), 1, 1, 1);
    chk("br.flush", 32'(flush3), 32'd1);
    chk("br.stall", 32'(stall3), 32'd0);
    idle();
    chk("br.flush_off", 32'(flush3), 32'd0);
    chk("br.sv0", 32'(sv3), 32'b010);
    idle(); idle(); idle();
    chk("br.retired", ret3, 32'd1);

    // Memory wait for three cycles with a coincident taken branch.
    do_reset();
    step(i_addi(10, 0, 1), 1, 1, 0);
    step(i_lw(3, 1), 1, 1, 0);
    step(i_beq(1, 2), 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(i_addi(11, 0, 1), 1, 0, 1);
      chk("mw.stall", 32'(stall3), 32'd1);
      chk("mw.flush", 32'(flush3), 32'd0);
      chk("mw.wb_en", 32'(we3), 32'd0);
      chk("mw.sv", 32'(sv3), 32'b111);
    end
    step(i_addi(11, 0, 1), 1, 1, 1);
    chk("mw.release_flush", 32'(flush3), 32'd1);
    chk("mw.release_wb", 32'(we3), 32'd1);
    chk("mw.release_rd", 32'(wr3), 32'd10);

    // x0 destinations and stores never forward.
    do_reset();
    step(i_addi(0, 0, 1), 1, 1, 0);
    step(i_add(1, 0, 0), 1, 1, 0);
    chk("x0.fwd_a", 32'(fa3), 32'd0);
    chk("x0.fwd_b", 32'(fb3), 32'd0);
    step(i_sw(5, 1, 5), 1, 1, 0);
    step(i_add(6, 5, 5), 1, 1, 0);
    chk("st.fwd_a", 32'(fa3), 32'd0);
    chk("st.fwd_b", 32'(fb3), 32'd0);

    // Asynchronous reset mid-operation with all stages full and a freeze active.
    do_reset();
    for (int i = 1; i <= 4; i++) step(i_addi(i, 0, i), 1, 1, 0);
    step(i_add(9, 3, 2), 1, 0, 0);
    chk("ar.pre_stall", 32'(stall3), 32'd1);
    chk("ar.pre_sv", 32'(sv3), 32'b111);
    chk("ar.pre_ret", ret3, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar.sv3", 32'(sv3), 32'd0);
    chk("ar.ret3", ret3, 32'd0);
    chk("ar.stall", 32'(stall3), 32'd0);
    chk("ar.flush", 32'(flush3), 32'd0);
    chk("ar.fwd_a", 32'(fa3), 32'd0);
    chk("ar.fwd_b", 32'(fb3), 32'd0);
    chk("ar.wb_en", 32'(we3), 32'd0);
    chk("ar.wb_rd", 32'(wr3), 32'd0);
    chk("ar.sv5", 32'(sv5), 32'd0);
    inst = '0; inst_valid = 1'b0; mem_ready = 1'b1;
    #1 rst = 1'b0;

    // First instruction after reset retires DEPTH edges after capture.
    step(i_addi(1, 0, 1), 1, 1, 0);
    idle(); idle(); idle();
    chk("lat.ret_before", ret3, 32'd0);
    idle();
    chk("lat.ret_after", ret3, 32'd1);

    // Ten instructions through both depths.
    do_reset();
    for (int i = 0; i < 10; i++) step(i_addi(i + 1, 0, i), 1, 1, 0);
    for (int i = 0; i < 6; i++) idle();
    chk("d5.ret10", ret5, 32'd10);
    chk("d3.ret10", ret3, 32'd10);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset();
      step(rand_inst(), $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
